frame_buffer_scheduler: RTL
===========================

// Module: frame_buffer_scheduler
// PURPOSE
// - Sequences the shared 3x3-window frame buffer between camera fill (write) and filter scan (read).
// - Sits between the camera/fileRead source, the frameBuffer and the Sobel/edge stage.
// - Drives the buffer's readWrite select and raster-scans window-centre coordinates.
// - Hands each window downstream over a valid/ready handshake; signals completion per frame.
// PARAMETERS
// - WIDTH   768  image width in pixels
// - HEIGHT  512  image height in pixels
// - CW      11   coordinate width; must satisfy 2**CW > max(WIDTH,HEIGHT)
// - RD_LAT  1    cycles from scan_X/scan_Y change to valid window taps at the buffer (1..7)
// PORTS
// - CAMERA_CLK  in   1   sole clock, rising edge
// - rst         in   1   synchronous, active-low reset
// - start       in   1   pulse; arms fill of a new frame (honoured in IDLE/DONE only)
// - cam_valid   in   1   camera pixel present this cycle
// - writeDone   in   1   from frameBuffer: last pixel of frame stored
// - win_ready   in   1   downstream filter accepts current window
// - readWrite   out  1   1 = buffer in write (fill) mode, 0 = read (scan) mode
// - scan_X      out  CW  window-centre column, 0..WIDTH-1
// - scan_Y      out  CW  window-centre row, 0..HEIGHT-1
// - win_valid   out  1   window taps at scan_X/scan_Y are valid
// - border      out  1   centre on row 0/HEIGHT-1 or column 0/WIDTH-1 (qualified by win_valid)
// - busy        out  1   state is FILL or SCAN
// - frame_done  out  1   one-cycle pulse: last window accepted
// - err_overrun out  1   sticky: cam_valid seen outside FILL
// BEHAVIOUR
// - Reset (rst==0 at edge): state IDLE; readWrite=1; scan_X=scan_Y=0; win_valid=0; busy=0; frame_done=0; err_overrun=0; wait counter=0.
// - rst low mid-FILL or mid-SCAN aborts immediately. No partial-frame flush.
// - IDLE:
//   - start -> FILL (next cycle).
//   - readWrite held 1 so the camera may pre-write.
// - FILL:
//   - readWrite=1; busy=1.
//   - writeDone -> SCAN; load scan_X=scan_Y=0; wait counter=RD_LAT.
//   - start in FILL ignored.
// - SCAN:
//   - readWrite=0; busy=1.
//   - Wait counter decrements to 0; then win_valid=1.
//   - scan_X/scan_Y stable while win_valid && !win_ready.
//   - Handshake (win_valid && win_ready) advances the raster:
//     - X+1; at X==WIDTH-1, X->0 and Y+1.
//     - win_valid drops to 0; counter reloads RD_LAT.
//     - Throughput: one window per RD_LAT+1 cycles minimum.
//   - Handshake at X==WIDTH-1, Y==HEIGHT-1 -> DONE; frame_done=1 that cycle (registered, same edge as state change).
// - DONE:
//   - readWrite=1; win_valid=0; busy=0; scan coords hold last value.
//   - Next cycle -> IDLE, or -> FILL if start is high.
// - err_overrun set on cam_valid in SCAN/DONE; cleared only by reset. Does not alter sequencing.
// - border: combinational from scan_X/scan_Y compares; no extra latency.
// - writeDone outside FILL is ignored.
// - start and writeDone in the same FILL cycle: writeDone wins.
// - Counters are CW bits wide; no wrap beyond WIDTH-1/HEIGHT-1 is ever produced.
// STRUCTURE
// - Shared package fb_pkg:
//   - state encoding localparams ST_IDLE=2'd0, ST_FILL=2'd1, ST_SCAN=2'd2, ST_DONE=2'd3.
//   - RW_WRITE=1'b1 / RW_READ=1'b0.
//   - Default WIDTH/HEIGHT/CW.
// - One sub-module: raster_counter.
//   - CW-bit X/Y counter with enable, load-zero, and last-pixel flag; parameters WIDTH/HEIGHT.
// - FSM, RD_LAT wait counter and sticky error remain in the top module.
// TESTING (bench with WIDTH=4, HEIGHT=3, RD_LAT=1, CW=11)
// - Reset: hold rst=0 three cycles -> readWrite=1, win_valid=0, busy=0, frame_done=0, err_overrun=0.
// - Full frame, win_ready tied 1: start, writeDone 5 cycles later ->
//   - 12 windows in raster order (0,0)..(3,2), one every 2 cycles.
//   - frame_done pulses exactly once, on the (3,2) handshake.
//   - readWrite=0 only during SCAN.
// - Backpressure: hold win_ready=0 10 cycles at (2,1) -> scan_X=2, scan_Y=1, win_valid=1 stable;
//   - on release, next window is (3,1).
// - Border: during full scan -> border=1 for all centres except (1,1) and (2,1).
// - Overrun: cam_valid=1 for one cycle during SCAN -> err_overrun=1 and stays 1 through DONE/IDLE;
//   - window sequence unchanged.
// - Reset mid-SCAN at (1,2): rst=0 one cycle -> IDLE, win_valid=0, scan=(0,0);
//   - new start/writeDone restarts from (0,0).

Source files
------------

// File: rtl/frame_buffer_scheduler_pkg.sv
// Shared definitions for the frame buffer scheduler: FSM states,
// buffer read/write select levels and default image geometry.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int DEF_WIDTH  = 768;
  localparam int DEF_HEIGHT = 512;
  localparam int DEF_CW     = 11;

endpackage

// File: rtl/frame_buffer_scheduler_if.sv
// Control/handshake bundle between the scheduler and its surroundings
// (camera source, frame buffer, downstream filter).
interface frame_buffer_scheduler_if #(
  parameter int CW = fb_pkg::DEF_CW
) ();

  logic          start;
  logic          cam_valid;
  logic          writeDone;
  logic          win_ready;
  logic          readWrite;
  logic [CW-1:0] scan_X;
  logic [CW-1:0] scan_Y;
  logic          win_valid;
  logic          border;
  logic          busy;
  logic          frame_done;
  logic          err_overrun;

  // Environment side: drives requests, observes the scheduler.
  modport master (
    output start, cam_valid, writeDone, win_ready,
    input  readWrite, scan_X, scan_Y, win_valid, border, busy,
           frame_done, err_overrun
  );

  // Scheduler side.
  modport slave (
    input  start, cam_valid, writeDone, win_ready,
    output readWrite, scan_X, scan_Y, win_valid, border, busy,
           frame_done, err_overrun
  );

endinterface

// File: rtl/frame_buffer_scheduler_raster_counter.sv
// Raster X/Y counter for window centres. Clears to the origin, steps
// X then Y, and flags the final pixel so the caller can stop there.
module raster_counter #(
  parameter int WIDTH  = fb_pkg::DEF_WIDTH,
  parameter int HEIGHT = fb_pkg::DEF_HEIGHT,
  parameter int CW     = fb_pkg::DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          last
);

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          x_last;

  assign x_last = (x_q == CW'(WIDTH - 1));
  assign last   = x_last && (y_q == CW'(HEIGHT - 1));
  assign x      = x_q;
  assign y      = y_q;

  // Next position: clear wins, otherwise step; the last pixel holds so
  // the coordinates never leave the image.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (en && !last) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_q + CW'(1);
      end else begin
        x_d = x_q + CW'(1);
      end
    end
  end

  // Coordinate registers, synchronous active-low reset to the origin.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Frame buffer scheduler: alternates the shared window buffer between
// camera fill and filter scan, raster-scanning window centres and
// handing each window downstream over valid/ready.
module frame_buffer_scheduler
  import fb_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int CW     = DEF_CW,
  parameter int RD_LAT = 1
) (
  input  logic                        CAMERA_CLK,
  input  logic                        rst,
  frame_buffer_scheduler_if.slave     bus
);

  localparam logic [2:0] RD_LAT_V = 3'(RD_LAT);

  state_t        state_q, state_d;
  logic [2:0]    wait_q, wait_d;
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          err_q, err_d;

  logic          rc_en, rc_clr, rc_last;
  logic [CW-1:0] rc_x, rc_y;

  raster_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .CW    (CW)
  ) u_raster (
    .clk (CAMERA_CLK),
    .rst (rst),
    .en  (rc_en),
    .clr (rc_clr),
    .x   (rc_x),
    .y   (rc_y),
    .last(rc_last)
  );

  // Sequencing: fill until the buffer reports the frame stored, then scan
  // windows, waiting RD_LAT cycles after each coordinate change before
  // presenting the taps as valid.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    win_valid_d  = win_valid_q;
    frame_done_d = 1'b0;
    err_d        = err_q | (bus.cam_valid &&
                            (state_q == ST_SCAN || state_q == ST_DONE));
    rc_en        = 1'b0;
    rc_clr       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (bus.writeDone) begin
          state_d     = ST_SCAN;
          rc_clr      = 1'b1;
          wait_d      = RD_LAT_V;
          win_valid_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (win_valid_q) begin
          if (bus.win_ready) begin
            win_valid_d = 1'b0;
            wait_d      = RD_LAT_V;
            if (rc_last) begin
              state_d      = ST_DONE;
              frame_done_d = 1'b1;
            end else begin
              rc_en = 1'b1;
            end
          end
        end else if (wait_q > 3'd1) begin
          wait_d = wait_q - 3'd1;
        end else begin
          // Counter reaches zero this edge, so the taps are valid next cycle.
          wait_d      = 3'd0;
          win_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        win_valid_d = 1'b0;
        state_d     = bus.start ? ST_FILL : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, wait counter, handshake and status registers.
  always_ff @(posedge CAMERA_CLK) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      wait_q       <= 3'd0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign bus.readWrite   = (state_q == ST_SCAN) ? RW_READ : RW_WRITE;
  assign bus.busy        = (state_q == ST_FILL) || (state_q == ST_SCAN);
  assign bus.scan_X      = rc_x;
  assign bus.scan_Y      = rc_y;
  assign bus.win_valid   = win_valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.err_overrun = err_q;
  assign bus.border      = (rc_x == '0) || (rc_x == CW'(WIDTH - 1)) ||
                           (rc_y == '0) || (rc_y == CW'(HEIGHT - 1));

endmodule
